// File: rtl/rv32_pipe_pkg.sv
// Shared RV32 pipeline constants: datapath widths and the bubble encoding
// used wherever a stage has nothing valid to present.
package rv32_pipe_pkg;

    localparam int          XLEN_DEF      = 32;
    localparam int          ILEN_DEF      = 32;
    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0

endpackage

// File: rtl/pipe_fifo.sv
// Small power-of-two FIFO with a ready/valid handshake on both sides and a
// synchronous flush. Storage is left unreset; only pointers and count are.
module pipe_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic push;
    logic pop;

    // Ready/valid depend only on registered state, so a full buffer never
    // passes a word straight through in the cycle it is being drained.
    assign wr_ready = (count_q != FULL_CNT);
    assign rd_valid = (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;

    assign push = wr_valid && wr_ready && !flush;
    assign pop  = rd_valid && rd_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly PTR_W bits, so DEPTH-1 wraps to 0 for free.
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/if_id_buf.sv
// Fetch-to-decode skid buffer: queues {pc, instruction} pairs and presents a
// clean bubble (pc 0, NOP) toward decode whenever the queue is empty.
module if_id_buf
    import rv32_pipe_pkg::*;
#(
    parameter int               XLEN      = XLEN_DEF,
    parameter int               ILEN      = ILEN_DEF,
    parameter int               DEPTH     = 2,
    parameter logic [ILEN-1:0]  NOP_INSTR = ILEN'(NOP_INSTR_DEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          pc,
    input  logic [ILEN-1:0]          instruction,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          pc_de,
    output logic [ILEN-1:0]          instr_de,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ENTRY_W = XLEN + ILEN;

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic               head_valid;
    logic [XLEN-1:0]    head_pc;
    logic [ILEN-1:0]    head_instr;

    assign wr_entry = {pc, instruction};

    pipe_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .wr_valid (in_valid),
        .wr_ready (in_ready),
        .wr_data  (wr_entry),
        .rd_valid (head_valid),
        .rd_ready (out_ready),
        .rd_data  (head_entry),
        .count    (count)
    );

    assign head_pc    = head_entry[ILEN +: XLEN];
    assign head_instr = head_entry[ILEN-1:0];
    assign out_valid  = head_valid;

    // Unwritten storage may hold X; decode must only ever see a defined bubble.
    always_comb begin
        pc_de    = '0;
        instr_de = NOP_INSTR;
        if (head_valid) begin
            pc_de    = head_pc;
            instr_de = head_instr;
        end
    end

endmodule

// File: tb/tb_if_id_buf.sv
// Directed bench for if_id_buf: a DEPTH=2 instance for handshake/flush cases
// and a DEPTH=4 instance for ordering across pointer wrap and async reset.
`timescale 1ns/1ps
module tb_if_id_buf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] pc;
    logic [31:0] instruction;

    logic        in_ready2, out_valid2;
    logic [31:0] pc_de2, instr_de2;
    logic [1:0]  count2;

    logic        in_ready4, out_valid4;
    logic [31:0] pc_de4, instr_de4;
    logic [2:0]  count4;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int compared   = 0;
    int mismatched = 0;

    if_id_buf #(.DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .pc(pc), .instruction(instruction),
        .out_valid(out_valid2), .out_ready(out_ready),
        .pc_de(pc_de2), .instr_de(instr_de2), .count(count2)
    );

    if_id_buf #(.DEPTH(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready4),
        .pc(pc), .instruction(instruction),
        .out_valid(out_valid4), .out_ready(out_ready),
        .pc_de(pc_de4), .instr_de(instr_de4), .count(count4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pq[$];
        logic [31:0] iq[$];
        int  idx;
        int  popped;
        int  mcount;
        bit  mpush;
        bit  mpop;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        pc = '0; instruction = '0;

        // asynchronous reset state, before any clock edge
        #2;
        chk("rst_instr",    64'(instr_de2),  64'(NOP));
        chk("rst_pc",       64'(pc_de2),     64'(0));
        chk("rst_out_valid",64'(out_valid2), 64'(0));
        chk("rst_in_ready", 64'(in_ready2),  64'(1));
        chk("rst_count",    64'(count2),     64'(0));

        @(posedge clk); #1;
        rst = 1'b0;
        step();
        chk("idle_instr",     64'(instr_de2),  64'(NOP));
        chk("idle_out_valid", 64'(out_valid2), 64'(0));

        // single push with decode ready
        in_valid = 1'b1; pc = 32'h100; instruction = 32'h0050_0093; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("one_out_valid", 64'(out_valid2), 64'(1));
        chk("one_pc",        64'(pc_de2),     64'(32'h100));
        chk("one_instr",     64'(instr_de2),  64'(32'h0050_0093));
        chk("one_count",     64'(count2),     64'(1));
        step();
        chk("one_bubble_valid", 64'(out_valid2), 64'(0));
        chk("one_bubble_instr", 64'(instr_de2),  64'(NOP));
        chk("one_bubble_pc",    64'(pc_de2),     64'(0));

        // stall absorption up to DEPTH, then release
        out_ready = 1'b0; in_valid = 1'b1; pc = 32'h100; instruction = 32'hA0;
        step();
        chk("stall_count1", 64'(count2), 64'(1));
        pc = 32'h104; instruction = 32'hA4;
        step();
        chk("stall_count2",   64'(count2),    64'(2));
        chk("stall_in_ready", 64'(in_ready2), 64'(0));
        chk("stall_head_pc",  64'(pc_de2),    64'(32'h100));
        pc = 32'h108; instruction = 32'hA8;
        step();
        chk("full_refused_count", 64'(count2),    64'(2));
        chk("full_stable_pc",     64'(pc_de2),    64'(32'h100));
        chk("full_stable_instr",  64'(instr_de2), 64'(32'hA0));
        out_ready = 1'b1;
        step();
        chk("full_pop_count", 64'(count2),    64'(1));
        chk("full_pop_head",  64'(pc_de2),    64'(32'h104));
        chk("full_pop_ready", 64'(in_ready2), 64'(1));
        step();
        in_valid = 1'b0;
        chk("pushpop_count", 64'(count2),    64'(1));
        chk("pushpop_head",  64'(pc_de2),    64'(32'h108));
        chk("pushpop_instr", 64'(instr_de2), 64'(32'hA8));
        step();
        chk("drain_valid", 64'(out_valid2), 64'(0));

        // flush while full drops both the queue and the incoming entry
        out_ready = 1'b0; in_valid = 1'b1; pc = 32'h300; instruction = 32'hB0;
        step();
        pc = 32'h304; instruction = 32'hB4;
        step();
        chk("preflush_count", 64'(count2), 64'(2));
        flush = 1'b1; pc = 32'h200; instruction = 32'hC0;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 64'(count2),    64'(0));
        chk("flush_valid", 64'(out_valid2), 64'(0));
        chk("flush_instr", 64'(instr_de2), 64'(NOP));
        chk("flush_pc",    64'(pc_de2),    64'(0));
        out_ready = 1'b1;
        step();
        chk("flush_no_emit", 64'(out_valid2), 64'(0));
        in_valid = 1'b1; pc = 32'h400; instruction = 32'hD0;
        step();
        in_valid = 1'b0;
        chk("postflush_pc",    64'(pc_de2),    64'(32'h400));
        chk("postflush_count", 64'(count2),    64'(1));

        // DEPTH=4 ordering through pointer wrap with random decode stalls
        rst = 1'b1;
        step();
        rst = 1'b0;
        idx = 0; popped = 0; mcount = 0;
        for (int cyc = 0; cyc < 80 && popped < 10; cyc++) begin
            in_valid    = (idx < 10);
            pc          = 32'h1000 + 32'(idx * 4);
            instruction = 32'h0010_0093 + 32'(idx << 7);
            out_ready   = (cyc >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
            mpush = in_valid && (mcount != 4);
            mpop  = (mcount != 0) && out_ready;
            chk("d4_out_valid", 64'(out_valid4), 64'(mcount != 0));
            chk("d4_in_ready",  64'(in_ready4),  64'(mcount != 4));
            if (mpop) begin
                chk("d4_order_pc",    64'(pc_de4),    64'(pq[0]));
                chk("d4_order_instr", 64'(instr_de4), 64'(iq[0]));
            end
            step();
            if (mpop) begin
                void'(pq.pop_front());
                void'(iq.pop_front());
                popped++;
            end
            if (mpush) begin
                pq.push_back(pc);
                iq.push_back(instruction);
                idx++;
            end
            mcount = mcount + int'(mpush) - int'(mpop);
        end
        in_valid = 1'b0;
        chk("d4_all_popped", 64'(popped), 64'(10));
        chk("d4_drained",    64'(count4), 64'(0));

        // async reset mid-stream gives an immediate bubble
        out_ready = 1'b0; in_valid = 1'b1; pc = 32'h2000; instruction = 32'hE0;
        step();
        pc = 32'h2004; instruction = 32'hE4;
        step();
        chk("d4_prerst_count", 64'(count4), 64'(2));
        #2;
        rst = 1'b1;
        #1;
        chk("d4_rst_valid", 64'(out_valid4), 64'(0));
        chk("d4_rst_instr", 64'(instr_de4),  64'(NOP));
        chk("d4_rst_pc",    64'(pc_de4),     64'(0));
        chk("d4_rst_count", 64'(count4),     64'(0));
        chk("d4_rst_ready", 64'(in_ready4),  64'(1));
        @(posedge clk); #1;
        rst = 1'b0; pc = 32'h3000; instruction = 32'hF0;
        step();
        in_valid = 1'b0;
        chk("d4_first_push_valid", 64'(out_valid4), 64'(1));
        chk("d4_first_push_pc",    64'(pc_de4),     64'(32'h3000));
        chk("d4_first_push_count", 64'(count4),     64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/if_id_buf.md
IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 Parameter XLEN, default 32, PC width in bits.
REQ-002 Parameter ILEN, default 32, instruction width in bits.
REQ-003 Parameter DEPTH, default 2, buffer entries; power of two, >= 2.
REQ-004 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), bubble encoding.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 flush  in  1  discard all buffered entries (branch/trap redirect).
REQ-008 in_valid  in  1  fetch presents a valid pc/instruction.
REQ-009 in_ready  out  1  buffer can accept this cycle.
REQ-010 pc  in  XLEN  fetch PC.
REQ-011 instruction  in  ILEN  fetched instruction.
REQ-012 out_valid  out  1  head entry valid toward decode.
REQ-013 out_ready  in  1  decode consumes head this cycle (deasserted = stall).
REQ-014 pc_de  out  XLEN  head PC, or 0 when empty.
REQ-015 instr_de  out  ILEN  head instruction, or NOP_INSTR when empty.
REQ-016 count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-017 Push SHALL occur when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
REQ-018 in_ready SHALL equal (count != DEPTH), combinational from state only; no same-cycle pass-through when full.
REQ-019 out_valid SHALL equal (count != 0); pc_de/instr_de SHALL be driven from the head entry.
REQ-020 Latency: an entry pushed at edge N SHALL appear on out_valid/pc_de/instr_de after edge N (1 cycle).
REQ-021 When out_valid=0, instr_de SHALL be NOP_INSTR and pc_de SHALL be 0 (bubble, never X).
REQ-022 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-023 Write/read pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-024 Order SHALL be strictly FIFO; no entry reordered, duplicated or lost except by flush.
REQ-025 flush SHALL have priority over push and pop: next cycle count=0, pointers=0, out_valid=0, and that cycle's in_valid entry is dropped.
REQ-026 While out_ready=0 and buffer not full, pushes SHALL continue to be accepted (stall absorption up to DEPTH entries).
REQ-027 Head outputs SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-028 On rst: count=0, pointers=0, out_valid=0, in_ready=1, pc_de=0, instr_de=NOP_INSTR, immediately and asynchronously.
REQ-029 rst asserted mid-operation SHALL discard all entries; storage array contents need not be reset.
REQ-030 First push SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-031 XLEN, ILEN and NOP_INSTR defaults SHALL come from the shared package rv32_pipe_pkg.
REQ-032 Storage and pointer logic SHALL be one sub-module, pipe_fifo (parametrised width XLEN+ILEN, DEPTH, with flush); if_id_buf adds bubble muxing.

Verification
REQ-033 Reset then idle: instr_de=32'h00000013, pc_de=0, out_valid=0, in_ready=1, count=0.
REQ-034 Push pc=0x100/instr=0x00500093 with out_ready=1: next cycle out_valid=1, pc_de=0x100, instr_de=0x00500093; following cycle back to bubble.
REQ-035 out_ready=0, push 0x100,0x104,0x108 (DEPTH=2): first two accepted, in_ready=0 on third, count=2; release out_ready: 0x100 then 0x104 emitted, then 0x108 accepted.
REQ-036 Full buffer, in_valid=1 and out_ready=1 same cycle: pop occurs, push refused (in_ready=0), count=1 next cycle.
REQ-037 count=2, flush with in_valid=1 pc=0x200: next cycle count=0, out_valid=0, instr_de=NOP; 0x200 never emitted.
REQ-038 DEPTH=4, 10 back-to-back pushes with random out_ready: output PC sequence equals input sequence (pointer wrap), rst pulse mid-stream yields bubble immediately.
